// File: rtl/rx_frame_controller.sv
// rtl/rx_frame_controller.sv - serial receive sequencing: start detect, bit timing, stop check, ready/overrun flags
module rx_frame_controller #(
    parameter int SAMPLES    = 16,
    parameter int FRAME_BITS = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       data_in,
    input  logic                       rd_ack,
    output logic                       shift_en,
    output logic [3:0]                 bit_index,
    output logic [$clog2(SAMPLES)-1:0] sample_count,
    output logic                       busy,
    output logic                       char_received,
    output logic                       framing_error,
    output logic                       overrun
);

    localparam int SW = $clog2(SAMPLES);
    localparam logic [SW-1:0] MID_SAMPLE  = SW'(SAMPLES / 2 - 1);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(SAMPLES - 1);
    localparam logic [3:0]    STOP_INDEX  = 4'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        DONE      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sample_count_q, sample_count_d;
    logic [3:0]    bit_index_q, bit_index_d;
    logic          shift_en_q, shift_en_d;
    logic          stop_bit_q, stop_bit_d;
    logic          char_received_q, char_received_d;
    logic          framing_error_q, framing_error_d;
    logic          overrun_q, overrun_d;

    // State, counters, strobe and flags; reset returns everything to zero/IDLE at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            sample_count_q  <= '0;
            bit_index_q     <= '0;
            shift_en_q      <= 1'b0;
            stop_bit_q      <= 1'b0;
            char_received_q <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            sample_count_q  <= sample_count_d;
            bit_index_q     <= bit_index_d;
            shift_en_q      <= shift_en_d;
            stop_bit_q      <= stop_bit_d;
            char_received_q <= char_received_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

    // Next state, sample/bit counters and the registered shift strobe
    always_comb begin
        state_d        = state_q;
        sample_count_d = sample_count_q + 1'b1;
        bit_index_d    = bit_index_q;
        shift_en_d     = 1'b0;
        stop_bit_d     = stop_bit_q;
        case (state_q)
            IDLE: begin
                sample_count_d = '0;
                bit_index_d    = '0;
                if (!data_in) state_d = START;
            end
            START: begin
                // Mid-bit check rejects glitches shorter than half a bit
                if (sample_count_q == MID_SAMPLE) begin
                    sample_count_d = '0;
                    if (data_in) begin
                        state_d = IDLE;
                    end else begin
                        shift_en_d  = 1'b1;
                        bit_index_d = 4'd1;
                        state_d     = DATA;
                    end
                end
            end
            DATA: begin
                if (sample_count_q == LAST_SAMPLE) begin
                    shift_en_d  = 1'b1;
                    bit_index_d = bit_index_q + 4'd1;
                    if (bit_index_q + 4'd1 == STOP_INDEX) state_d = STOP;
                end
            end
            STOP: begin
                if (sample_count_q == LAST_SAMPLE) begin
                    shift_en_d = 1'b1;
                    stop_bit_d = data_in;
                    state_d    = DONE;
                end
            end
            DONE: begin
                sample_count_d = '0;
                bit_index_d    = '0;
                state_d        = stop_bit_q ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                // A line stuck low after a bad stop must not look like a new start bit
                sample_count_d = '0;
                bit_index_d    = '0;
                if (data_in) state_d = IDLE;
            end
            default: begin
                state_d        = IDLE;
                sample_count_d = '0;
                bit_index_d    = '0;
            end
        endcase
        if (!enable) begin
            state_d        = IDLE;
            sample_count_d = '0;
            bit_index_d    = '0;
            shift_en_d     = 1'b0;
        end
    end

    // Sticky flags: ack clears, a completing frame in the same cycle sets on top of the clear
    always_comb begin
        char_received_d = char_received_q;
        framing_error_d = framing_error_q;
        overrun_d       = overrun_q;
        if (rd_ack) begin
            char_received_d = 1'b0;
            framing_error_d = 1'b0;
            overrun_d       = 1'b0;
        end
        if (state_q == DONE) begin
            if (stop_bit_q) begin
                char_received_d = 1'b1;
                if (char_received_q) overrun_d = 1'b1;
            end else begin
                framing_error_d = 1'b1;
            end
        end
    end

    // Outputs taken straight from state and registers
    always_comb begin
        busy          = (state_q != IDLE);
        shift_en      = shift_en_q;
        bit_index     = bit_index_q;
        sample_count  = sample_count_q;
        char_received = char_received_q;
        framing_error = framing_error_q;
        overrun       = overrun_q;
    end

endmodule

// File: tb/tb_rx_frame_controller.sv
// tb/tb_rx_frame_controller.sv - directed self-checking bench for rx_frame_controller
module tb_rx_frame_controller;

    localparam int SAMPLES    = 16;
    localparam int FRAME_BITS = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       data_in;
    logic       rd_ack;
    logic       shift_en;
    logic [3:0] bit_index;
    logic [3:0] sample_count;
    logic       busy;
    logic       char_received;
    logic       framing_error;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    logic [9:0] sr;

    rx_frame_controller #(.SAMPLES(SAMPLES), .FRAME_BITS(FRAME_BITS)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .data_in       (data_in),
        .rd_ack        (rd_ack),
        .shift_en      (shift_en),
        .bit_index     (bit_index),
        .sample_count  (sample_count),
        .busy          (busy),
        .char_received (char_received),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Reference shift register, captures the line at the edge after each strobe
    always @(posedge clk) if (shift_en) sr <= {data_in, sr[9:1]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one 160-cycle frame; iteration i drives edge T+i and observes the state after edge T+i-1
    task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_at,
                              output int nshift, output int nbad,
                              output logic cr152, output logic cr153,
                              output logic fe153, output logic ov153);
        logic [9:0] fr;
        int off;
        fr = {stop, d, 1'b0};
        nshift = 0; nbad = 0; cr152 = 0; cr153 = 0; fe153 = 0; ov153 = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            off = i - 1;
            if (i > 0 && shift_en) begin
                nshift++;
                if (off < 8 || ((off - 8) % 16) != 0) nbad++;
            end
            if (off == 152) cr152 = char_received;
            if (off == 153) begin
                cr153 = char_received;
                fe153 = framing_error;
                ov153 = overrun;
            end
            data_in = fr[i / 16];
            rd_ack  = (i == ack_at);
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    initial begin
        int ns, nb, cnt, bcnt;
        logic c152, c153, f153, o153;

        reset = 1'b1; enable = 1'b0; data_in = 1'b1; rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {shift_en, busy, char_received, framing_error, overrun, bit_index, sample_count}, 0);
        reset = 1'b0; enable = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 0);

        // Valid frame 0xA5
        send_frame(8'hA5, 1'b1, -1, ns, nb, c152, c153, f153, o153);
        check("a5_shift_count", ns, 10);
        check("a5_shift_timing", nb, 0);
        check("a5_cr_before", c152, 0);
        check("a5_cr_at_153", c153, 1);
        check("a5_framing", f153, 0);
        check("a5_data", sr, {1'b1, 8'hA5, 1'b0});
        pulse_ack();
        check("a5_ack_clears", char_received, 0);

        // False start: 4-cycle low glitch
        cnt = 0; bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (shift_en) cnt++;
                if (busy) bcnt++;
            end
            data_in = (i < 4) ? 1'b0 : 1'b1;
        end
        check("false_start_shifts", cnt, 0);
        check("false_start_busy_cycles", bcnt, SAMPLES / 2);
        check("false_start_flags", {char_received, framing_error, overrun}, 0);

        // Bad stop bit, line then held low
        send_frame(8'h5A, 1'b0, -1, ns, nb, c152, c153, f153, o153);
        check("badstop_shift_count", ns, 10);
        check("badstop_cr", c153, 0);
        check("badstop_fe", f153, 1);
        cnt = 0; bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (shift_en) cnt++;
            if (busy) bcnt++;
            data_in = 1'b0;
        end
        check("wait_idle_no_shift", cnt, 0);
        check("wait_idle_busy", bcnt, 40);
        @(negedge clk); data_in = 1'b1;
        repeat (2) @(negedge clk);
        check("wait_idle_release", busy, 0);
        pulse_ack();
        check("badstop_ack_clears", framing_error, 0);

        // Overrun: two frames with no ack
        send_frame(8'h3C, 1'b1, -1, ns, nb, c152, c153, f153, o153);
        check("ovr_first_cr", c153, 1);
        check("ovr_first_ov", o153, 0);
        send_frame(8'hC3, 1'b1, -1, ns, nb, c152, c153, f153, o153);
        check("ovr_second_flags", {c153, o153}, 2'b11);
        check("ovr_second_data", sr[8:1], 8'hC3);
        pulse_ack();
        check("ovr_ack_clears", {char_received, overrun}, 0);

        // Ack in the DONE cycle of the second frame
        send_frame(8'h11, 1'b1, -1, ns, nb, c152, c153, f153, o153);
        send_frame(8'h22, 1'b1, 153, ns, nb, c152, c153, f153, o153);
        check("simul_ack_flags", {c153, o153}, 2'b11);
        pulse_ack();
        check("simul_after_ack", {char_received, overrun}, 0);

        // Enable dropped at T+60
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i > 0 && shift_en) cnt++;
            if (i == 61) check("endrop_idle", {busy, bit_index, sample_count}, 0);
            if (i == 60) enable = 1'b0;
            data_in = (i < 16) ? 1'b0 : 1'b0;
        end
        check("endrop_shifts", cnt, 4);
        @(negedge clk); data_in = 1'b1;
        @(negedge clk); enable = 1'b1;
        repeat (3) @(negedge clk);
        check("endrop_no_cr", char_received, 0);
        send_frame(8'h96, 1'b1, -1, ns, nb, c152, c153, f153, o153);
        check("endrop_next_shifts", ns, 10);
        check("endrop_next_cr", c153, 1);
        check("endrop_next_data", sr[8:1], 8'h96);

        // Reset mid-frame, with char_received still set from the previous frame
        for (int i = 0; i < 51; i++) begin
            @(negedge clk);
            if (i == 50) begin
                reset = 1'b1;
                #1;
                check("midreset_outputs", {shift_en, busy, char_received, framing_error, overrun, bit_index, sample_count}, 0);
            end else begin
                data_in = (i < 16) ? 1'b0 : 1'b1;
            end
        end
        @(negedge clk);
        reset = 1'b0; data_in = 1'b1;
        cnt = 0; bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (shift_en) cnt++;
            if (busy) bcnt++;
        end
        check("postreset_no_shift", cnt, 0);
        check("postreset_idle", bcnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
